// File: rtl/data_mem_resp.sv
// ----------------------------------------------------------------------------
// data_mem_resp
//
// Data-side memory responder for a small CPU. It serves single-cycle word
// accesses to a local data RAM and to three memory-mapped registers:
//
//   0x0xxx_xxxx  data RAM (word index taken from the low address bits, the
//                remaining RAM-region bits alias)
//   0x1000_0000  TXDATA  write: push byte to transmit queue
//                        read : head byte (0 when empty), never pops
//   0x1000_0004  STATUS  {count[15:8], overflow[2], full[1], empty[0]}
//                        write data[2]=1 clears the sticky overflow flag
//   0x1000_0008  CYCLE   free-running 32-bit cycle counter, writable
//   anything else        reads 0, writes ignored
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_ce_i    CPU data access enable
//   data_we_i    1 = write, 0 = read (qualified by data_ce_i)
//   data_addr_i  byte address (bits [1:0] ignored, word accesses only)
//   data_i       store data from the CPU
//   data_o       load data to the CPU, combinational, 0 when not reading
//   tx_valid_o   transmit queue head is valid
//   tx_data_o    transmit queue head byte (0 when empty)
//   tx_ready_i   consumer accepts the head byte this cycle
// ----------------------------------------------------------------------------
module data_mem_resp #(
    parameter int unsigned RAM_WORDS = 256,
    parameter int unsigned TXQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_ce_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i
);

    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned QAW    = $clog2(TXQ_DEPTH);
    localparam int unsigned CW     = QAW + 1;

    // Word addresses (byte address >> 2) of the memory-mapped registers.
    localparam logic [29:0] TXDATA_WADDR = 30'h0400_0000;
    localparam logic [29:0] STATUS_WADDR = 30'h0400_0001;
    localparam logic [29:0] CYCLE_WADDR  = 30'h0400_0002;

    localparam logic [CW-1:0] QUEUE_FULL_CNT = CW'(TXQ_DEPTH);

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic rd_en;
    logic wr_en;
    logic sel_ram;
    logic sel_txdata;
    logic sel_status;
    logic sel_cycle;

    assign rd_en      = data_ce_i & ~data_we_i;
    assign wr_en      = data_ce_i & data_we_i;
    assign sel_ram    = (data_addr_i[31:28] == 4'h0);
    assign sel_txdata = (data_addr_i[31:2] == TXDATA_WADDR);
    assign sel_status = (data_addr_i[31:2] == STATUS_WADDR);
    assign sel_cycle  = (data_addr_i[31:2] == CYCLE_WADDR);

    // Byte offset within the word has no meaning: accesses are whole words.
    logic unused_byte_offset;
    assign unused_byte_offset = ^data_addr_i[1:0];

    // ------------------------------------------------------------------------
    // Data RAM
    // ------------------------------------------------------------------------
    // Not reset: contents survive rst_n. Reads are asynchronous, so a read in
    // the cycle of a write sees the old word.
    logic [31:0]       ram_q [RAM_WORDS];
    logic [RAM_AW-1:0] ram_idx;

    assign ram_idx = data_addr_i[2 +: RAM_AW];

    always_ff @(posedge clk) begin
        if (wr_en && sel_ram) begin
            ram_q[ram_idx] <= data_i;
        end
    end

    // ------------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------------
    logic [31:0] cycle_q;
    logic [31:0] cycle_d;

    // A software load replaces the increment for that edge.
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (wr_en && sel_cycle) begin
            cycle_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    // ------------------------------------------------------------------------
    // Transmit queue
    // ------------------------------------------------------------------------
    logic [7:0]     txq_q [TXQ_DEPTH];
    logic [QAW-1:0] rptr_q;
    logic [QAW-1:0] rptr_d;
    logic [QAW-1:0] wptr_q;
    logic [QAW-1:0] wptr_d;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_d;
    logic           ovf_q;
    logic           ovf_d;

    logic tx_empty;
    logic tx_full;
    logic pop;
    logic push_req;
    logic push_ok;
    logic ovf_clr;

    assign tx_empty = (count_q == '0);
    assign tx_full  = (count_q == QUEUE_FULL_CNT);
    assign pop      = ~tx_empty & tx_ready_i;
    assign push_req = wr_en & sel_txdata;
    // A pop at the same edge frees a slot, so a full queue still accepts.
    assign push_ok  = push_req & (~tx_full | pop);
    assign ovf_clr  = wr_en & sel_status & data_i[2];

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (pop) begin
            rptr_d = rptr_q + QAW'(1);
        end
        if (push_ok) begin
            wptr_d = wptr_q + QAW'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        // Clear takes priority over a simultaneous rejected push.
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            txq_q[wptr_q] <= data_i[7:0];
        end
    end

    // Head outputs depend only on registered state, never on tx_ready_i.
    assign tx_valid_o = ~tx_empty;
    assign tx_data_o  = tx_empty ? 8'h00 : txq_q[rptr_q];

    // ------------------------------------------------------------------------
    // Read data mux
    // ------------------------------------------------------------------------
    logic [31:0] status_word;

    assign status_word = {16'h0000, 8'(count_q), 5'b00000, ovf_q, tx_full, tx_empty};

    always_comb begin
        data_o = 32'h0000_0000;
        if (rd_en) begin
            if (sel_ram) begin
                data_o = ram_q[ram_idx];
            end else if (sel_txdata) begin
                data_o = {24'h00_0000, tx_data_o};
            end else if (sel_status) begin
                data_o = status_word;
            end else if (sel_cycle) begin
                data_o = cycle_q;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// ----------------------------------------------------------------------------
// tb_data_mem_resp
//
// Directed bench for data_mem_resp with default parameters (256-word RAM,
// 4-entry transmit queue). Inputs change 1 ns after a rising edge; outputs
// are sampled between edges.
// ----------------------------------------------------------------------------
module tb_data_mem_resp;

    localparam logic [31:0] A_TXDATA = 32'h1000_0000;
    localparam logic [31:0] A_STATUS = 32'h1000_0004;
    localparam logic [31:0] A_CYCLE  = 32'h1000_0008;
    localparam logic [31:0] A_UNMAP  = 32'h2000_0000;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    data_mem_resp #(
        .RAM_WORDS (256),
        .TXQ_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_ce_i   (ce),
        .data_we_i   (we),
        .data_addr_i (addr),
        .data_i      (wdata),
        .data_o      (rdata),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        ce    = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        ce = 1'b0;
        we = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ce   = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        check(tag, rdata, exp);
        ce = 1'b0;
    endtask

    logic [7:0] drain_exp [4];

    initial begin
        rst_n    = 1'b0;
        ce       = 1'b0;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
        tx_ready = 1'b0;

        // Reset state
        #3;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_data_o_idle", rdata, 32'h0);
        read_check("rst_cycle", A_CYCLE, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0000_0001);
        #7;
        rst_n = 1'b1;
        step();
        read_check("cycle_first_inc", A_CYCLE, 32'h0000_0001);

        // RAM write then same-cycle reads, including alias and byte offset
        bus_write(32'h0000_0010, 32'hDEAD_BEEF);
        read_check("ram_0x10", 32'h0000_0010, 32'hDEAD_BEEF);
        read_check("ram_alias_0x410", 32'h0000_0410, 32'hDEAD_BEEF);
        read_check("ram_offset_0x13", 32'h0000_0013, 32'hDEAD_BEEF);

        // Overflow: five pushes into a 4-deep queue with no consumer
        for (int i = 0; i < 5; i++) begin
            bus_write(A_TXDATA, 32'hFFFF_FF41 + i);
        end
        read_check("status_full_ovf", A_STATUS, 32'h0000_0406);
        check("txq_head_valid", {31'b0, tx_valid}, 32'h1);
        read_check("txdata_read_no_pop", A_TXDATA, 32'h0000_0041);
        check("txq_head_after_read", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain1_valid", {31'b0, tx_valid}, 32'h1);
            check("drain1_data", {24'b0, tx_data}, 32'h41 + i);
            step();
        end
        check("drain1_empty_valid", {31'b0, tx_valid}, 32'h0);
        check("drain1_empty_data", {24'b0, tx_data}, 32'h0);
        tx_ready = 1'b0;
        read_check("status_empty_ovf", A_STATUS, 32'h0000_0005);
        read_check("txdata_empty", A_TXDATA, 32'h0);
        bus_write(A_STATUS, 32'h0000_0004);
        read_check("status_ovf_cleared", A_STATUS, 32'h0000_0001);

        // Push into a full queue while it pops: accepted, no overflow
        for (int i = 0; i < 4; i++) begin
            bus_write(A_TXDATA, 32'h50 + i);
        end
        read_check("status_full", A_STATUS, 32'h0000_0402);
        tx_ready = 1'b1;
        bus_write(A_TXDATA, 32'h0000_0055);
        read_check("status_push_pop", A_STATUS, 32'h0000_0402);
        drain_exp[0] = 8'h51;
        drain_exp[1] = 8'h52;
        drain_exp[2] = 8'h53;
        drain_exp[3] = 8'h55;
        for (int i = 0; i < 4; i++) begin
            check("drain2_valid", {31'b0, tx_valid}, 32'h1);
            check("drain2_data", {24'b0, tx_data}, {24'b0, drain_exp[i]});
            step();
        end
        check("drain2_empty", {31'b0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        read_check("status_after_drain2", A_STATUS, 32'h0000_0001);

        // Cycle counter load and wrap
        bus_write(A_CYCLE, 32'hFFFF_FFFE);
        read_check("cycle_load", A_CYCLE, 32'hFFFF_FFFE);
        step();
        read_check("cycle_max", A_CYCLE, 32'hFFFF_FFFF);
        step();
        read_check("cycle_wrap", A_CYCLE, 32'h0000_0000);

        // Unmapped space, read-only fields, disabled access
        bus_write(32'h0000_0000, 32'hA5A5_A5A5);
        read_check("unmapped_read", A_UNMAP, 32'h0);
        read_check("unmapped_mmio_read", 32'h1000_000C, 32'h0);
        ce    = 1'b1;
        we    = 1'b1;
        addr  = A_UNMAP;
        wdata = 32'hFFFF_FFFF;
        #1;
        check("write_phase_data_o", rdata, 32'h0);
        step();
        ce = 1'b0;
        we = 1'b0;
        read_check("unmapped_wr_ram0", 32'h0000_0000, 32'hA5A5_A5A5);
        read_check("unmapped_wr_ram10", 32'h0000_0010, 32'hDEAD_BEEF);
        read_check("unmapped_wr_status", A_STATUS, 32'h0000_0001);
        bus_write(A_STATUS, 32'hFFFF_FFFB);
        read_check("status_ro_write", A_STATUS, 32'h0000_0001);
        ce   = 1'b0;
        we   = 1'b0;
        addr = 32'h0000_0010;
        #1;
        check("ce_low_data_o", rdata, 32'h0);

        // Asynchronous reset mid-cycle with bytes queued
        step();
        for (int i = 0; i < 3; i++) begin
            bus_write(A_TXDATA, 32'h1 + i);
        end
        bus_write(A_CYCLE, 32'd100);
        read_check("pre_rst_cycle", A_CYCLE, 32'd100);
        check("pre_rst_valid", {31'b0, tx_valid}, 32'h1);
        read_check("pre_rst_status", A_STATUS, 32'h0000_0300);
        rst_n = 1'b0;
        #1;
        check("arst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("arst_tx_data", {24'b0, tx_data}, 32'h0);
        read_check("arst_status", A_STATUS, 32'h0000_0001);
        read_check("arst_cycle", A_CYCLE, 32'h0);
        rst_n = 1'b1;
        read_check("ram_kept_after_rst", 32'h0000_0010, 32'hDEAD_BEEF);
        step();
        read_check("cycle_after_rst", A_CYCLE, 32'h0000_0001);
        check("post_rst_empty", {31'b0, tx_valid}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
